// File: rtl/cmd_issuer.sv
// DDR command issuer: pops {cmd,addr} entries from a FWFT issue FIFO, enforces bank-0 timing, drives registered command pins.
// Optional macro CMD_ISSUER_CNT_EN enables the saturating issued-command counter; otherwise issued_cnt is tied to 0.
module cmd_issuer #(
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 14,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 3,
    parameter int T_RAS  = 7,
    parameter int T_CCD  = 2,
    parameter int T_RTP  = 2,
    parameter int T_WR   = 6,
    parameter int T_RFC  = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    isu_fifo_empty,
    input  logic [CMD_W+ADDR_W-1:0] isu_fifo_dout,
    output logic                    isu_fifo_rd,
    output logic                    dram_cs_n,
    output logic                    dram_ras_n,
    output logic                    dram_cas_n,
    output logic                    dram_we_n,
    output logic [ADDR_W-1:0]       dram_addr,
    output logic [2:0]              dram_ba,
    output logic                    cmd_err,
    output logic                    issuer_idle,
    output logic [15:0]             issued_cnt
);

    localparam logic [CMD_W-1:0] OP_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_ACT   = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_READ  = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_WRITE = CMD_W'(3);
    localparam logic [CMD_W-1:0] OP_PRE   = CMD_W'(4);
    localparam logic [CMD_W-1:0] OP_PREA  = CMD_W'(5);
    localparam logic [CMD_W-1:0] OP_RDA   = CMD_W'(6);
    localparam logic [CMD_W-1:0] OP_WRA   = CMD_W'(7);
    localparam logic [CMD_W-1:0] OP_REF   = CMD_W'(8);

    // Pin codes are {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] PINS_DESEL = 4'b1111;
    localparam logic [3:0] PINS_NOP   = 4'b0111;
    localparam logic [3:0] PINS_ACT   = 4'b0011;
    localparam logic [3:0] PINS_READ  = 4'b0101;
    localparam logic [3:0] PINS_WRITE = 4'b0100;
    localparam logic [3:0] PINS_PRE   = 4'b0010;
    localparam logic [3:0] PINS_REF   = 4'b0001;

    localparam logic [7:0] G_RCD   = 8'(T_RCD - 1);
    localparam logic [7:0] G_RP    = 8'(T_RP - 1);
    localparam logic [7:0] G_RAS   = 8'(T_RAS - 1);
    localparam logic [7:0] G_CCD   = 8'(T_CCD - 1);
    localparam logic [7:0] G_RTP   = 8'(T_RTP - 1);
    localparam logic [7:0] G_WR    = 8'(T_WR - 1);
    localparam logic [7:0] G_RFC   = 8'(T_RFC - 1);
    localparam logic [7:0] G_AP_RD = 8'(T_RTP + T_RP - 1);
    localparam logic [7:0] G_AP_WR = 8'(T_WR + T_RP - 1);
    localparam logic [7:0] I_ACT   = 8'(((T_RCD > T_RAS) ? T_RCD : T_RAS) - 1);

    logic [7:0] cnt_act_q, cnt_pre_q, cnt_rd_q, cnt_wr_q, cnt_cas_q, cnt_ref_q;
    logic [7:0] cnt_act_d, cnt_pre_d, cnt_rd_d, cnt_wr_d, cnt_cas_d, cnt_ref_d;
    logic       ap_rd_q, ap_wr_q, ap_rd_d, ap_wr_d;
    logic [3:0] pins_q, pins_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic       err_q, err_d;

    logic [CMD_W-1:0]  head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic gate_act, gate_cas, gate_pre, gate_ref;
    logic gate, defined, issue;
    logic is_act, is_cas, is_rd, is_wr, is_pre, is_ref, set_ap_rd, set_ap_wr;
    logic a10_force, a10_val;
    logic [3:0] pins_code;

    function automatic logic [7:0] tick(input logic [7:0] c, input logic clr);
        if (clr)
            return 8'd0;
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign head_cmd  = isu_fifo_dout[CMD_W+ADDR_W-1:ADDR_W];
    assign head_addr = isu_fifo_dout[ADDR_W-1:0];

    assign gate_act = (cnt_pre_q >= G_RP) && (cnt_ref_q >= G_RFC) &&
                      (!ap_rd_q || cnt_rd_q >= G_AP_RD) && (!ap_wr_q || cnt_wr_q >= G_AP_WR);
    assign gate_cas = (cnt_act_q >= G_RCD) && (cnt_cas_q >= G_CCD);
    assign gate_pre = (cnt_act_q >= G_RAS) && (cnt_rd_q >= G_RTP) && (cnt_wr_q >= G_WR);
    assign gate_ref = (cnt_pre_q >= G_RP) && (cnt_ref_q >= G_RFC);

    always_comb begin
        gate      = 1'b1;
        defined   = 1'b1;
        is_act    = 1'b0;
        is_cas    = 1'b0;
        is_rd     = 1'b0;
        is_wr     = 1'b0;
        is_pre    = 1'b0;
        is_ref    = 1'b0;
        set_ap_rd = 1'b0;
        set_ap_wr = 1'b0;
        a10_force = 1'b0;
        a10_val   = 1'b0;
        pins_code = PINS_NOP;
        case (head_cmd)
            OP_NOP:   ;
            OP_ACT:   begin is_act = 1'b1; gate = gate_act; pins_code = PINS_ACT; end
            OP_READ:  begin is_cas = 1'b1; is_rd = 1'b1; gate = gate_cas; pins_code = PINS_READ;
                            a10_force = 1'b1; end
            OP_WRITE: begin is_cas = 1'b1; is_wr = 1'b1; gate = gate_cas; pins_code = PINS_WRITE;
                            a10_force = 1'b1; end
            OP_PRE:   begin is_pre = 1'b1; gate = gate_pre; pins_code = PINS_PRE; a10_force = 1'b1; end
            OP_PREA:  begin is_pre = 1'b1; gate = gate_pre; pins_code = PINS_PRE;
                            a10_force = 1'b1; a10_val = 1'b1; end
            OP_RDA:   begin is_cas = 1'b1; is_rd = 1'b1; set_ap_rd = 1'b1; gate = gate_cas;
                            pins_code = PINS_READ; a10_force = 1'b1; a10_val = 1'b1; end
            OP_WRA:   begin is_cas = 1'b1; is_wr = 1'b1; set_ap_wr = 1'b1; gate = gate_cas;
                            pins_code = PINS_WRITE; a10_force = 1'b1; a10_val = 1'b1; end
            OP_REF:   begin is_ref = 1'b1; gate = gate_ref; pins_code = PINS_REF; end
            default:  defined = 1'b0;
        endcase
    end

    // Undefined opcodes have gate=1 so they are drained immediately and only flag cmd_err.
    always_comb begin
        isu_fifo_rd = rst_n & ~isu_fifo_empty & gate;
        issue       = isu_fifo_rd & defined & (head_cmd != OP_NOP);

        cnt_act_d = tick(cnt_act_q, issue & is_act);
        cnt_pre_d = tick(cnt_pre_q, issue & is_pre);
        cnt_rd_d  = tick(cnt_rd_q,  issue & is_rd);
        cnt_wr_d  = tick(cnt_wr_q,  issue & is_wr);
        cnt_cas_d = tick(cnt_cas_q, issue & is_cas);
        cnt_ref_d = tick(cnt_ref_q, issue & is_ref);

        ap_rd_d = ap_rd_q;
        ap_wr_d = ap_wr_q;
        if (issue && is_act) begin
            ap_rd_d = 1'b0;
            ap_wr_d = 1'b0;
        end
        if (issue && set_ap_rd)
            ap_rd_d = 1'b1;
        if (issue && set_ap_wr)
            ap_wr_d = 1'b1;

        pins_d = issue ? pins_code : PINS_NOP;
        addr_d = addr_q;
        if (issue) begin
            addr_d = head_addr;
            if (a10_force)
                addr_d[10] = a10_val;
        end
        err_d = err_q | (isu_fifo_rd & ~defined);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_act_q <= 8'hFF;
            cnt_pre_q <= 8'hFF;
            cnt_rd_q  <= 8'hFF;
            cnt_wr_q  <= 8'hFF;
            cnt_cas_q <= 8'hFF;
            cnt_ref_q <= 8'hFF;
            ap_rd_q   <= 1'b0;
            ap_wr_q   <= 1'b0;
            pins_q    <= PINS_DESEL;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_act_q <= cnt_act_d;
            cnt_pre_q <= cnt_pre_d;
            cnt_rd_q  <= cnt_rd_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_cas_q <= cnt_cas_d;
            cnt_ref_q <= cnt_ref_d;
            ap_rd_q   <= ap_rd_d;
            ap_wr_q   <= ap_wr_d;
            pins_q    <= pins_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = pins_q;
    assign dram_addr = addr_q;
    assign dram_ba   = 3'b000;
    assign cmd_err   = err_q;

    // Idle means no pending constraint of any kind could still hold off the next command.
    assign issuer_idle = isu_fifo_empty &&
                         (cnt_act_q >= I_ACT) && (cnt_pre_q >= G_RP) &&
                         (cnt_rd_q >= G_AP_RD) && (cnt_wr_q >= G_AP_WR) &&
                         (cnt_cas_q >= G_CCD) && (cnt_ref_q >= G_RFC);

`ifdef CMD_ISSUER_CNT_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;

    always_comb begin
        issued_cnt_d = issued_cnt_q;
        if (issue && issued_cnt_q != 16'hFFFF)
            issued_cnt_d = issued_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issued_cnt_q <= 16'd0;
        else
            issued_cnt_q <= issued_cnt_d;
    end

    assign issued_cnt = issued_cnt_q;
`else
    assign issued_cnt = 16'd0;
`endif

endmodule
